// File: rtl/multiboot_request_arbiter.sv
// multiboot_request_arbiter
// Arbitrates warm-reboot requests from NREQ independent sources and drives a
// single ICAP multiboot sequencer. A rising edge on req[i] makes requester i
// pending. Pending requests are granted in fixed priority, where the lowest
// index wins. The winning address is latched and held, and exactly one reboot
// strobe is issued per grant.
//
// Optional feature macro: MULTIBOOT_LOCK_EN. When it is defined, a `lock`
// input holds the arbiter in IDLE. Edges are still captured while lock is high.
//
// Ports:
//   clk_icap    in   1         block clock, rising edge
//   rst_n       in   1         synchronous reset, active low
//   req         in   NREQ      request levels; only rising edges count
//   req_addr    in   24*NREQ   per-requester flash address, sampled at grant
//   lock        in   1         (MULTIBOOT_LOCK_EN only) inhibit new grants
//   mbt_reboot  out  1         one-cycle reboot strobe
//   spi_addr    out  24        latched bitstream address
//   busy        out  1         high from ARM entry until WAIT exit
//   gnt_id      out  3         index of the requester currently/last served
//   ack         out  NREQ      one-cycle completion pulse for served requester
module multiboot_request_arbiter #(
  parameter int          NREQ         = 4,
  parameter int          SEQ_CYCLES   = 32,
  parameter logic [23:0] DEFAULT_ADDR = 24'h0B0000
) (
  input  logic              clk_icap,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [24*NREQ-1:0] req_addr,
`ifdef MULTIBOOT_LOCK_EN
  input  logic              lock,
`endif
  output logic              mbt_reboot,
  output logic [23:0]       spi_addr,
  output logic              busy,
  output logic [2:0]        gnt_id,
  output logic [NREQ-1:0]   ack
);

  localparam int CW = $clog2(SEQ_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_FIRE = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  logic [1:0]      state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [NREQ-1:0] req_d_reg;
  logic [NREQ-1:0] held_reg;
  logic [NREQ-1:0] pend_reg;
  logic [NREQ-1:0] pend_next;
  logic [NREQ-1:0] rise;
  logic [NREQ-1:0] sel_mask;
  logic            win_valid;
  logic [2:0]      win_idx;
  logic [23:0]     win_addr;
  logic            lock_gate;
  logic            grant;

`ifdef MULTIBOOT_LOCK_EN
  assign lock_gate = lock;
`else
  assign lock_gate = 1'b0;
`endif

  // held_reg masks any requester whose level was already high while in reset.
  // Such a requester must fall and rise again before it counts as a request.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_edge
      assign rise[gi] = req[gi] & ~req_d_reg[gi] & ~held_reg[gi];
    end
  endgenerate

  // Fixed priority: scan from the top so the lowest pending index is the last
  // one written.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    win_addr  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pend_reg[i]) begin
        win_valid = 1'b1;
        win_idx   = 3'(i);
        win_addr  = req_addr[24*i +: 24];
      end
    end
  end

  assign grant    = (state_reg == S_IDLE) && win_valid && !lock_gate;
  assign sel_mask = grant ? (NREQ'(1) << win_idx) : '0;
  // A new edge in the same cycle as the clear takes priority, so the bit stays set.
  assign pend_next = (pend_reg & ~sel_mask) | rise;

  assign mbt_reboot = (state_reg == S_FIRE);

  always_ff @(posedge clk_icap) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      req_d_reg <= '0;
      held_reg  <= req;
      pend_reg  <= '0;
      busy      <= 1'b0;
      ack       <= '0;
      gnt_id    <= '0;
      spi_addr  <= DEFAULT_ADDR;
    end else begin
      req_d_reg <= req;
      held_reg  <= held_reg & req;
      pend_reg  <= pend_next;
      ack       <= '0;
      case (state_reg)
        S_IDLE: begin
          if (grant) begin
            state_reg <= S_ARM;
            spi_addr  <= (win_addr == 24'h000000) ? DEFAULT_ADDR : win_addr;
            gnt_id    <= win_idx;
            busy      <= 1'b1;
          end
        end
        S_ARM:  state_reg <= S_FIRE;
        S_FIRE: begin
          state_reg <= S_WAIT;
          cnt_reg   <= CW'(SEQ_CYCLES - 1);
        end
        S_WAIT: begin
          if (cnt_reg == '0) begin
            state_reg <= S_IDLE;
            busy      <= 1'b0;
            ack       <= NREQ'(1) << gnt_id;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiboot_request_arbiter.sv
// Testbench for multiboot_request_arbiter.
// A transaction-level reference model runs on each rising edge. It tracks
// pending requests as a set and tracks when the arbiter is next free to grant.
// On each grant, it pushes the expected reboot and ack records into queues.
// A separate monitor runs on falling edges. It pops those queues and compares
// them against the DUT outputs.
module tb_multiboot_request_arbiter;
  localparam int          NREQ = 4;
  localparam int          S    = 32;
  localparam logic [23:0] DEF  = 24'h0B0000;

  typedef struct {
    int          id;
    logic [23:0] addr;
    int          pulse_edge;
    int          ack_edge;
  } exp_t;

  logic                 clk_icap = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [24*NREQ-1:0]   req_addr;
`ifdef MULTIBOOT_LOCK_EN
  logic                 lock;
`endif
  logic                 mbt_reboot;
  logic [23:0]          spi_addr;
  logic                 busy;
  logic [2:0]           gnt_id;
  logic [NREQ-1:0]      ack;

  always #5 clk_icap = ~clk_icap;

  multiboot_request_arbiter #(
    .NREQ(NREQ), .SEQ_CYCLES(S), .DEFAULT_ADDR(DEF)
  ) dut (
    .clk_icap  (clk_icap),
    .rst_n     (rst_n),
    .req       (req),
    .req_addr  (req_addr),
`ifdef MULTIBOOT_LOCK_EN
    .lock      (lock),
`endif
    .mbt_reboot(mbt_reboot),
    .spi_addr  (spi_addr),
    .busy      (busy),
    .gnt_id    (gnt_id),
    .ack       (ack)
  );

  exp_t            pulse_q[$];
  exp_t            ack_q[$];
  int              cyc      = 0;
  int              idle_at  = 0;
  int              busy_end = 0;
  int              checks   = 0;
  int              errors   = 0;
  logic [NREQ-1:0] pend_m   = '0;
  logic [NREQ-1:0] prev_m   = '0;
  logic [23:0]     cur_addr = DEF;
  logic [2:0]      cur_id   = '0;
  bit              rst_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %h required %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_icap);
  endtask

  task automatic set_addr(input int i, input logic [23:0] a);
    req_addr[24*i +: 24] = a;
  endtask

  task automatic set_lock(input logic v);
`ifdef MULTIBOOT_LOCK_EN
    lock = v;
`else
    if (v) $display("note: lock requested but feature not built");
`endif
  endtask

  // Reference model, evaluated at each rising edge.
  initial begin
    exp_t        e;
    int          g;
    logic [23:0] a;
    logic        lock_eff;
    forever begin
      @(posedge clk_icap);
      cyc++;
`ifdef MULTIBOOT_LOCK_EN
      lock_eff = lock;
`else
      lock_eff = 1'b0;
`endif
      if (!rst_n) begin
        pend_m   = '0;
        idle_at  = cyc + 1;
        busy_end = 0;
        cur_addr = DEF;
        cur_id   = '0;
        pulse_q.delete();
        ack_q.delete();
        rst_seen = 1'b1;
      end else begin
        rst_seen = 1'b0;
        if (cyc >= idle_at && pend_m != '0 && !lock_eff) begin
          g = 0;
          for (int i = 0; i < NREQ; i++) begin
            if (pend_m[i]) begin
              g = i;
              break;
            end
          end
          a = req_addr[24*g +: 24];
          if (a == 24'h000000) a = DEF;
          pend_m[g]    = 1'b0;
          e.id         = g;
          e.addr       = a;
          e.pulse_edge = cyc + 1;
          e.ack_edge   = cyc + 2 + S;
          pulse_q.push_back(e);
          ack_q.push_back(e);
          cur_addr = a;
          cur_id   = 3'(g);
          busy_end = cyc + 2 + S;
          idle_at  = cyc + 3 + S;
        end
        pend_m = pend_m | (req & ~prev_m);
      end
      prev_m = req;
    end
  end

  // Monitor, evaluated at each falling edge.
  initial begin
    logic            exp_p;
    logic [NREQ-1:0] exp_ack;
    exp_t            h;
    forever begin
      @(negedge clk_icap);
      if (cyc > 0) begin
        if (rst_seen) begin
          chk("rst_reboot", 32'(mbt_reboot), 32'd0);
          chk("rst_busy",   32'(busy),       32'd0);
          chk("rst_ack",    32'(ack),        32'd0);
          chk("rst_gnt_id", 32'(gnt_id),     32'd0);
          chk("rst_spi",    32'(spi_addr),   32'(DEF));
        end else begin
          exp_p = (pulse_q.size() > 0) && (pulse_q[0].pulse_edge == cyc);
          chk("reboot", 32'(mbt_reboot), 32'(exp_p));
          if (exp_p) begin
            h = pulse_q.pop_front();
            $display("reboot cycle %0d id %0d spi_addr %h (expected id %0d addr %h)",
                     cyc, gnt_id, spi_addr, h.id, h.addr);
          end
          exp_ack = '0;
          if (ack_q.size() > 0 && ack_q[0].ack_edge == cyc) begin
            h = ack_q.pop_front();
            exp_ack[h.id] = 1'b1;
            $display("ack cycle %0d ack %b (expected %b)", cyc, ack, exp_ack);
          end
          chk("ack",      32'(ack),      32'(exp_ack));
          chk("busy",     32'(busy),     32'(cyc < busy_end));
          chk("spi_addr", 32'(spi_addr), 32'(cur_addr));
          chk("gnt_id",   32'(gnt_id),   32'(cur_id));
        end
      end
    end
  end

  // Stimulus.
  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_addr = '0;
    set_lock(1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Single request from requester 2.
    set_addr(2, 24'h058000);
    req[2] = 1'b1; tick(1); req[2] = 1'b0;
    tick(45);

    // Two simultaneous requests: 1 is served before 3.
    set_addr(1, 24'h030000);
    set_addr(3, 24'h0B0000);
    req[1] = 1'b1; req[3] = 1'b1; tick(2); req = '0;
    tick(90);

    // A zero address is replaced by the default address.
    set_addr(0, 24'h000000);
    req[0] = 1'b1; tick(1); req[0] = 1'b0;
    tick(45);

    // Repeated edges while busy coalesce; later address changes are ignored.
    set_addr(2, 24'h123456);
    set_addr(0, 24'h0C0000);
    req[2] = 1'b1; tick(1); req[2] = 1'b0;
    tick(10);
    repeat (3) begin
      req[0] = 1'b1; tick(1); req[0] = 1'b0; tick(1);
    end
    repeat (90) begin
      set_addr(0, 24'($urandom));
      set_addr(2, 24'($urandom));
      tick(1);
    end

    // Reset during WAIT with requester 1 pending and held high.
    set_addr(2, 24'h0A0000);
    req[2] = 1'b1; tick(1); req[2] = 1'b0;
    tick(8);
    req[1] = 1'b1;
    tick(5);
    rst_n = 1'b0; tick(3); rst_n = 1'b1;
    tick(50);
    req[1] = 1'b0;
    tick(3);

`ifdef MULTIBOOT_LOCK_EN
    // Lock holds the arbiter in IDLE; release grants on the next edge.
    set_lock(1'b1);
    req[0] = 1'b1; tick(1); req[0] = 1'b0;
    tick(100);
    set_lock(1'b0);
    tick(45);
`endif

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
        if ($urandom_range(0, 3) == 0) set_addr(i, 24'h000000);
        else                           set_addr(i, 24'($urandom));
      end
`ifdef MULTIBOOT_LOCK_EN
      if ($urandom_range(0, 29) == 0) lock = ~lock;
`endif
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0; tick(2); rst_n = 1'b1;
      end else begin
        tick(1);
      end
    end

    // Drain all outstanding work before the final check.
    req = '0;
    set_lock(1'b0);
    tick(400);
    chk("drain_pulse_q", 32'(pulse_q.size()), 32'd0);
    chk("drain_ack_q",   32'(ack_q.size()),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiboot_request_arbiter.md
# multiboot_request_arbiter

Arbitrates warm-reboot requests from up to NREQ independent sources (front-panel button, keyboard hotkey, host register write, watchdog) and drives the single ICAP multiboot sequencer. Each requester presents its own 24-bit SPI flash bitstream address. The block latches the winning address, holds it stable for the whole ICAP command sequence, and issues exactly one reboot pulse per granted request. It sits between the request sources and the Spartan-6 multiboot sequencer in the `clk_icap` domain.

## Interface
- NREQ, 4: number of requesters, 2..8.
- SEQ_CYCLES, 32: cycles `spi_addr` is held after the pulse; covers the sequencer's 15-word ICAP stream plus margin. Must be ≥16.
- DEFAULT_ADDR, 24'h0B0000: substituted when a requester's address is 24'h000000.
- clk_icap  in  1  block clock; everything is synchronous to its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req  in  NREQ  per-requester request level; only a rising edge counts as a request.
- req_addr  in  24*NREQ  flattened addresses; requester i uses bits [24*i+23:24*i], sampled at grant.
- mbt_reboot  out  1  one-cycle reboot strobe to the sequencer.
- spi_addr  out  24  bitstream address to the sequencer, stable from ARM through WAIT.
- busy  out  1  high from ARM entry until WAIT exit.
- gnt_id  out  3  index of the requester currently or last served.
- ack  out  NREQ  one-cycle completion pulse for the served requester.
- lock  in  1  only present with MULTIBOOT_LOCK_EN.

## Operation
- Edge capture: `req_d` holds `req` registered; `pend[i]` is set when `req[i] & ~req_d[i]`.
- States:
  - IDLE → ARM when `pend != 0`. Grant is fixed priority, lowest index wins.
  - ARM → FIRE unconditionally.
  - FIRE → WAIT unconditionally.
  - WAIT → IDLE when `cnt == 0`.
- IDLE→ARM transition:
  - `spi_addr <= (addr_i == 0) ? DEFAULT_ADDR : addr_i`.
  - `gnt_id <= i`, `busy <= 1`, `pend[i] <= 0`.
- FIRE: `mbt_reboot` is high for exactly this state.
- FIRE→WAIT: `cnt <= SEQ_CYCLES-1`.
- WAIT: `cnt` decrements each cycle. On exit:
  - `ack[gnt_id]` pulses one cycle.
  - `busy <= 0`.
  - `spi_addr` holds its value until the next grant.
- Simultaneous events:
  - An edge arriving in the same cycle that its pend bit is cleared at ARM entry wins, so `pend` stays 1.
  - Edges on any index during ARM, FIRE or WAIT are captured and served afterwards, in priority order.
  - Repeated edges on one index while it is pending coalesce into one request.
- `req_addr` changes after the grant cycle have no effect on the request in flight.
- On real hardware the FPGA reconfigures during WAIT. Reaching IDLE only occurs in simulation or on a failed reboot.

## Timing
- Reset values while `rst_n` is low:
  - state IDLE, `pend` 0, `req_d` 0, `cnt` 0.
  - `mbt_reboot` 0, `busy` 0, `ack` 0, `gnt_id` 0, `spi_addr` DEFAULT_ADDR.
- Reset mid-sequence aborts immediately and discards all pending requests. A `req` held high through reset is not a request until it falls and rises again.
- Latency: `req[i]` first seen high at edge t.
  - `pend[i]` = 1 after edge t.
  - ARM (busy = 1, `spi_addr` valid) after edge t+1.
  - `mbt_reboot` = 1 after edge t+2, cleared after edge t+3.
  - `ack` high after edge t+3+SEQ_CYCLES, for one cycle.
- `spi_addr` is valid one full cycle before `mbt_reboot` rises and is held ≥ SEQ_CYCLES cycles after it.
- Back-to-back grants: minimum spacing between `mbt_reboot` pulses is SEQ_CYCLES+3 cycles.

## Configuration
- MULTIBOOT_LOCK_EN defined:
  - `lock` port exists.
  - While `lock`=1, IDLE does not leave IDLE. Edges are still captured into `pend`.
  - Releasing `lock` grants the highest-priority pending request on the next edge.
  - `lock` is ignored once ARM is entered; an in-flight sequence always completes.
- MULTIBOOT_LOCK_EN undefined: no `lock` port; the IDLE→ARM transition is unconditional on `pend != 0`.

## Test plan
- Reset, then pulse `req[2]` with addr 24'h058000 → one `mbt_reboot` cycle 3 edges later, `spi_addr`=24'h058000, `gnt_id`=2, `ack[2]` after SEQ_CYCLES more cycles.
- `req[1]` and `req[3]` rise in the same cycle (addrs 24'h030000, 24'h0B0000) → grant 1 first, then 3. Exactly two pulses, spaced SEQ_CYCLES+3 cycles.
- Requester 0 with addr 24'h000000 → `spi_addr`=24'h0B0000 (DEFAULT_ADDR).
- `req[0]` toggled 3 times during WAIT of another grant → exactly one additional grant to 0. Change `req_addr` after grant → `spi_addr` unchanged.
- Assert `rst_n`=0 during WAIT with `req[1]` pending → all outputs at reset values, no further pulse. `req[1]` held high through reset produces no request.
- With MULTIBOOT_LOCK_EN: `lock`=1, pulse `req[0]` → no pulse for 100 cycles. Drop `lock` → `mbt_reboot` 2 edges later.
